// File: rtl/apb_regbank_pkg.sv
// ----------------------------------------------------------------------------
// apb_regbank_pkg: shared types and bit positions for apb_cfg_regbank.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package apb_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int CTRL_IDX   = 0;
  localparam int START_BIT  = 0;
  localparam int IRQ_EN_BIT = 1;
  localparam int DONE_BIT   = 0;
  localparam int BUSY_BIT   = 1;
  localparam int CNT_W      = 3;

endpackage

`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
// ----------------------------------------------------------------------------
// apb_wait_ctrl: APB transfer tracker with programmable PREADY wait states.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_wait_ctrl
  import apb_regbank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  output logic ready
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = (state == ACCESS) && (cnt == CNT_W'(WAIT_STATES));
    case (state)
      IDLE: begin
        // An enable phase without a prior setup phase is not a transfer
        if (psel && !penable) state_nxt = SETUP;
      end
      SETUP: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (penable) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (ready || !psel) state_nxt = IDLE;
        else                cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/apb_cfg_regbank.sv
// ----------------------------------------------------------------------------
// apb_cfg_regbank: APB3 config register bank with STATUS, start pulse and irq.
// Macro APB_REGBANK_PSTRB_EN adds PSTRB byte-lane write strobes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_cfg_regbank
  import apb_regbank_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_REGS        = 4,
  parameter int WAIT_STATES     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic                          PWRITE,
  input  logic [AMBA_WORD-1:0]          PWDATA,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs_o,
  output logic                          start,
  input  logic                          busy_i,
  input  logic                          done_i,
`ifdef APB_REGBANK_PSTRB_EN
  input  logic [AMBA_WORD/8-1:0]        PSTRB,
`endif
  output logic                          irq
);

  logic [NUM_REGS-1:0][AMBA_WORD-1:0] regs;
  logic [AMBA_ADDR_WIDTH-1:0]         idx;
  logic [AMBA_WORD/8-1:0]             strb;
  logic                               ready;
  logic                               legal;
  logic                               is_status;
  logic                               wr_xfer;
  logic                               rd_xfer;
  logic                               wr_ok;
  logic                               status_rd;
  logic                               done_sticky;

`ifdef APB_REGBANK_PSTRB_EN
  assign strb = PSTRB;
`else
  assign strb = '1;
`endif

  apb_wait_ctrl #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .psel    (PSEL),
    .penable (PENABLE),
    .ready   (ready)
  );

  assign idx       = PADDR >> 2;
  assign legal     = (PADDR[1:0] == 2'b00) && (idx < AMBA_ADDR_WIDTH'(NUM_REGS));
  assign is_status = (idx == AMBA_ADDR_WIDTH'(NUM_REGS));
  assign wr_xfer   = ready && PWRITE;
  assign rd_xfer   = ready && !PWRITE;
  assign wr_ok     = wr_xfer && legal && !busy_i;
  assign status_rd = rd_xfer && is_status;

  assign PREADY  = ready;
  assign PSLVERR = (wr_xfer && (!legal || busy_i)) ||
                   (rd_xfer && !legal && !is_status);
  assign regs_o  = regs;
  assign irq     = done_sticky && regs[CTRL_IDX][IRQ_EN_BIT];

  always_comb begin
    PRDATA = '0;
    if (rd_xfer) begin
      if (legal) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (idx == AMBA_ADDR_WIDTH'(i)) PRDATA = regs[i];
        end
      end else if (is_status) begin
        PRDATA[DONE_BIT] = done_sticky;
        PRDATA[BUSY_BIT] = busy_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs        <= '0;
      start       <= 1'b0;
      done_sticky <= 1'b0;
    end else begin
      start <= wr_ok && (idx == AMBA_ADDR_WIDTH'(CTRL_IDX)) &&
               PWDATA[START_BIT] && strb[START_BIT/8];
      // CTRL start bit drops as the pulse ends; a new write in that cycle wins
      if (start) regs[CTRL_IDX][START_BIT] <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < AMBA_WORD/8; b++) begin
          if (wr_ok && (idx == AMBA_ADDR_WIDTH'(i)) && strb[b])
            regs[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
        end
      end
      if (done_i)         done_sticky <= 1'b1;
      else if (status_rd) done_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_cfg_regbank.sv
// ----------------------------------------------------------------------------
// tb_apb_cfg_regbank: directed self-checking bench for apb_cfg_regbank.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_apb_cfg_regbank;
  import apb_regbank_pkg::*;

  localparam int W  = 32;
  localparam int AW = 20;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic          busy = 1'b0, done = 1'b0, use3 = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [W-1:0]  pwdata = '0;
  logic          psel_a, psel_b;

  logic [W-1:0]   prdata, prdata3;
  logic           pready, pready3, pslverr, pslverr3;
  logic           start, start3, irq, irq3;
  logic [N*W-1:0] regs, regs3;

  int checks = 0;
  int errors = 0;

  assign psel_a = psel & ~use3;
  assign psel_b = psel & use3;

  always #5 clk = ~clk;

  apb_cfg_regbank #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(N), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .PSEL(psel_a), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr), .regs_o(regs), .start(start), .busy_i(busy),
    .done_i(done),
`ifdef APB_REGBANK_PSTRB_EN
    .PSTRB(4'hF),
`endif
    .irq(irq)
  );

  apb_cfg_regbank #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(N), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .PSEL(psel_b), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .regs_o(regs3), .start(start3), .busy_i(busy),
    .done_i(done),
`ifdef APB_REGBANK_PSTRB_EN
    .PSTRB(4'hF),
`endif
    .irq(irq3)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit s3, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                      output logic [W-1:0] rd, output logic err, output int n);
    @(posedge clk); #1;
    use3 = s3; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (n <= 20) begin
      @(negedge clk);
      if ((s3 ? pready3 : pready) === 1'b1) break;
      n++;
    end
    rd  = s3 ? prdata3 : prdata;
    err = s3 ? pslverr3 : pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_wr(input string tag, input bit s3, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic exp_err);
    logic [W-1:0] r; logic e; int n;
    xfer(s3, 1'b1, a, d, r, e, n);
    check({tag, " latency"}, 128'(n), 128'(s3 ? 4 : 3));
    check({tag, " pslverr"}, 128'(e), 128'(exp_err));
    check({tag, " prdata"},  128'(r), 128'(0));
  endtask

  task automatic do_rd(input string tag, input bit s3, input logic [AW-1:0] a,
                       input logic [W-1:0] exp_d, input logic exp_err);
    logic [W-1:0] r; logic e; int n;
    xfer(s3, 1'b0, a, '0, r, e, n);
    check({tag, " latency"}, 128'(n), 128'(s3 ? 4 : 3));
    check({tag, " pslverr"}, 128'(e), 128'(exp_err));
    check({tag, " prdata"},  128'(r), 128'(exp_d));
  endtask

  initial begin
    logic seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst prdata",  128'(prdata),  128'(0));
    check("rst pready",  128'(pready),  128'(0));
    check("rst pslverr", 128'(pslverr), 128'(0));
    check("rst start",   128'(start),   128'(0));
    check("rst irq",     128'(irq),     128'(0));
    check("rst regs",    128'(regs),    128'(0));
    rst = 1'b0;

    // Plain write/read with two wait states
    do_wr("wr reg1", 1'b0, 20'h004, 32'h1234_5678, 1'b0);
    do_rd("rd reg1", 1'b0, 20'h004, 32'h1234_5678, 1'b0);
    check("regs_o word1", 128'(regs[63:32]), 128'(32'h1234_5678));

    // CTRL start pulse and self-clearing start bit
    do_wr("wr ctrl", 1'b0, 20'h000, 32'h3, 1'b0);
    @(negedge clk);
    check("start high", 128'(start), 128'(1));
    check("ctrl image during start", 128'(regs[31:0]), 128'(32'h3));
    @(negedge clk);
    check("start low", 128'(start), 128'(0));
    check("ctrl image after start", 128'(regs[31:0]), 128'(32'h2));
    do_rd("rd ctrl", 1'b0, 20'h000, 32'h2, 1'b0);

    // Writes while busy are rejected
    do_wr("wr reg2", 1'b0, 20'h008, 32'h0000_00AA, 1'b0);
    busy = 1'b1;
    do_wr("wr reg2 busy", 1'b0, 20'h008, 32'hFFFF_FFFF, 1'b1);
    do_wr("wr ctrl busy", 1'b0, 20'h000, 32'h1, 1'b1);
    @(negedge clk);
    check("no start when busy", 128'(start), 128'(0));
    busy = 1'b0;
    do_rd("rd reg2 old", 1'b0, 20'h008, 32'h0000_00AA, 1'b0);

    // done -> sticky -> irq, cleared by STATUS read
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    check("irq set", 128'(irq), 128'(1));
    do_rd("rd status", 1'b0, 20'h010, 32'h1, 1'b0);
    @(negedge clk);
    check("irq cleared", 128'(irq), 128'(0));
    busy = 1'b1;
    do_rd("rd status busy", 1'b0, 20'h010, 32'h2, 1'b0);
    busy = 1'b0;

    // done in the same cycle as the STATUS read keeps the sticky bit
    @(posedge clk); #1 done = 1'b1;
    do_rd("rd status w/ done", 1'b0, 20'h010, 32'h1, 1'b0);
    done = 1'b0;
    @(negedge clk);
    check("irq kept", 128'(irq), 128'(1));
    do_rd("rd status again", 1'b0, 20'h010, 32'h1, 1'b0);
    @(negedge clk);
    check("irq cleared again", 128'(irq), 128'(0));

    // Illegal accesses
    do_rd("rd 0x014", 1'b0, 20'h014, 32'h0, 1'b1);
    do_rd("rd 0x002", 1'b0, 20'h002, 32'h0, 1'b1);
    do_wr("wr 0x002", 1'b0, 20'h002, 32'hFF, 1'b1);
    do_wr("wr status", 1'b0, 20'h010, 32'h3, 1'b1);
    check("ctrl untouched", 128'(regs[31:0]), 128'(32'h2));

    // Enable phase with no setup phase is ignored
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 20'h004; pwdata = 32'hBAD;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pready !== 1'b0) seen = 1'b1;
    end
    check("no setup pready", 128'(seen), 128'(0));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    check("no setup reg1", 128'(regs[63:32]), 128'(32'h1234_5678));

    // Abort mid-ACCESS on the three-wait-state instance
    @(posedge clk); #1;
    use3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h004; pwdata = 32'hDEAD;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort pready", 128'(pready3), 128'(0));
    @(negedge clk);
    check("abort reg1", 128'(regs3[63:32]), 128'(0));
    check("abort idle", 128'(dut3.u_wait.state), 128'(IDLE));
    do_rd("ws3 rd reg1", 1'b1, 20'h004, 32'h0, 1'b0);
    do_wr("ws3 wr reg1", 1'b1, 20'h004, 32'h55, 1'b0);
    do_rd("ws3 rd reg1 new", 1'b1, 20'h004, 32'h55, 1'b0);

    // Reset on the completing edge of a CTRL write
    @(posedge clk); #1;
    use3 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h000; pwdata = 32'h1;
    @(posedge clk); #1 penable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset pready", 128'(pready), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    check("mid rst regs",   128'(regs),   128'(0));
    check("mid rst pready", 128'(pready), 128'(0));
    check("mid rst start",  128'(start),  128'(0));
    check("mid rst state",  128'(dut.u_wait.state), 128'(IDLE));
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_cfg_regbank.md
Name: apb_cfg_regbank

Overview:
- Parametrised APB3 slave register bank; successor to the fixed 4-register APB front-end of the encoder/decoder core.
- Provides NUM_REGS read/write config registers, a read-only STATUS register, PREADY with programmable wait states, PSLVERR on illegal accesses, a one-cycle start pulse to the core and a sticky done/irq path back.
- Sits between the APB interconnect and the codec datapath.

Parameters:
- AMBA_WORD, 32, data bus and register width in bits.
- AMBA_ADDR_WIDTH, 20, PADDR width in bits.
- NUM_REGS, 4, number of R/W config registers (2..16). Index 0 is CTRL.
- WAIT_STATES, 0, extra access-phase cycles before PREADY (0..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PADDR  in  AMBA_ADDR_WIDTH  byte address
- PWRITE  in  1  1=write, 0=read
- PWDATA  in  AMBA_WORD  write data
- PRDATA  out  AMBA_WORD  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error, qualified by PREADY
- regs_o  out  NUM_REGS*AMBA_WORD  flat register image; reg i at [i*AMBA_WORD +: AMBA_WORD]
- start  out  1  one-cycle start pulse to core
- busy_i  in  1  core busy
- done_i  in  1  core done pulse
- irq  out  1  interrupt

Behaviour:
- Reset is synchronous, active-high on rst; clock is clk. All registers, done_sticky, FSM and wait counter clear to 0. Outputs in reset: PRDATA=0, PREADY=0, PSLVERR=0, start=0, irq=0, regs_o=0.
- Decode: word index idx = PADDR>>2.
  - Legal R/W: PADDR[1:0]==0 and idx<NUM_REGS.
  - STATUS: idx==NUM_REGS, read-only.
  - Any other address is illegal.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE->SETUP on PSEL&!PENABLE.
  - SETUP->ACCESS on PSEL&PENABLE.
  - SETUP->IDLE on !PSEL.
  - ACCESS->IDLE when PREADY=1 or PSEL=0 (abort, no side effects).
  - PENABLE without a preceding SETUP is ignored; FSM stays in IDLE and PREADY stays 0.
- Wait counter: cleared on entry to ACCESS, increments each ACCESS cycle. PREADY = (state==ACCESS) & (cnt==WAIT_STATES), combinational. Access latency is WAIT_STATES+1 cycles after the setup cycle.
- Write (PREADY & PWRITE, legal, busy_i=0): reg[idx] <= PWDATA at that edge; PSLVERR=0.
- Write errors give PSLVERR=1 with no state change:
  - illegal address;
  - STATUS address;
  - any write while busy_i=1.
- Read (PREADY & !PWRITE): PRDATA = reg[idx] for a legal address.
  - STATUS read returns {zeros, busy_i, done_sticky} with bit0=done_sticky and bit1=busy_i, and clears done_sticky at that edge.
  - Illegal read address: PRDATA=0, PSLVERR=1.
  - PRDATA=0 whenever PREADY=0.
- start: registered; high for exactly one cycle following a completed, error-free write to CTRL (idx 0) with PWDATA[0]=1.
- CTRL[0] is self-clearing: it reads 0 from the cycle after start.
- done_sticky: set by done_i, cleared by STATUS read. If both occur in the same cycle, set wins.
- irq = done_sticky & CTRL[1].
- regs_o is a direct register view; it updates the cycle after the write edge.

Optional Feature:
- Macro APB_REGBANK_PSTRB_EN.
- Defined: adds input PSTRB [AMBA_WORD/8]; on a write, only byte lanes with PSTRB[b]=1 are updated. start fires only if PSTRB[0]=1 and PWDATA[0]=1. PSTRB==0 on a write is a legal no-op with PSLVERR=0.
- Undefined: no PSTRB port; every write updates the full word.

Decomposition:
- Package apb_regbank_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - CTRL_IDX=0;
  - CTRL bit positions (START_BIT=0, IRQ_EN_BIT=1);
  - STATUS bit positions (DONE_BIT=0, BUSY_BIT=1).
- One sub-module, apb_wait_ctrl: FSM, wait counter, PREADY generation. The top level holds decode, storage, start/done/irq.

Test Plan:
- WAIT_STATES=2: write 0x1234_5678 to 0x004 -> PREADY rises 3 cycles after setup, PSLVERR=0; a following read of 0x004 returns 0x1234_5678 and regs_o word1 matches.
- Write 0x3 to CTRL (0x000) with busy_i=0 -> start high for exactly 1 cycle; a subsequent CTRL read returns 0x2.
- Hold busy_i=1 and write 0xFFFF_FFFF to 0x008 -> PSLVERR=1; a read of 0x008 returns the old value.
- Pulse done_i with CTRL[1]=1 -> irq=1. STATUS read (0x010 for NUM_REGS=4) returns 0x1; irq=0 next cycle. Repeat with done_i in the same cycle as the read -> done_sticky stays 1.
- Access addresses 0x014 and 0x002, and write STATUS -> PSLVERR=1, PRDATA=0. Abort: PSEL dropped mid-ACCESS with WAIT_STATES=3 -> no register change, FSM returns to IDLE.
- Assert rst in the middle of an ACCESS write -> next cycle all regs_o=0, PREADY=0, start=0, FSM in IDLE.
